rf_rename_ckpt: RTL and testbench
=================================

Name: rf_rename_ckpt

Overview:
- Parametrised successor to the single-port architectural register file / rename table that sits between Decoder, ROB and dispatch.
- Holds committed register values and, per register, the ROB tag of its newest in-flight producer.
- Adds N read ports and M commit ports.
- Adds K dependency-table checkpoints, so branch mispredict recovery restores the rename state without a full ROB clear.

Parameters:
XLEN, 32, register data width
NREG, 32, architectural register count (index width RW = clog2(NREG))
TAG_W, 4, ROB tag width (`ROB_SIZE_BIT)
NRD, 4, read ports (2 per decoded instruction, 2 instructions)
NCM, 2, commit ports; port 0 is oldest
NCK, 4, checkpoint slots (index width CW = clog2(NCK))

Ports:
clk_in  in  1  clock, all state on rising edge
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  low = hold every register, no state change
rob_clear  in  1  full flush
cm_en  in  NCM  commit valid per port
cm_id  in  NCM*RW  commit destination register
cm_tag  in  NCM*TAG_W  ROB tag of committing instruction
cm_val  in  NCM*XLEN  committed value
dp_en  in  1  rename (dispatch) valid
dp_id  in  RW  renamed destination register
dp_tag  in  TAG_W  new producer tag
ck_save  in  1  take checkpoint
ck_save_id  in  CW  slot to write
ck_rest  in  1  restore checkpoint
ck_rest_id  in  CW  slot to restore
ck_rel  in  1  release slot (branch resolved correctly)
ck_rel_id  in  CW  slot to release
rd_id  in  NRD*RW  read register indices
rd_val  out  NRD*XLEN  value (combinational)
rd_dep  out  NRD*TAG_W  producer tag (combinational)
rd_has_dep  out  NRD  1 = value not yet available
ck_valid  out  NCK  registered slot-occupied bitmap
err  out  1  sticky: commit to register with has_dep=0, or restore of invalid slot

Behaviour:
- Reset (async): all NREG values, tags, has_dep = 0; all snapshots invalid; ck_valid = 0; err = 0. Register 0 is always value 0 and has_dep 0; commits and dispatch to id 0 are ignored on every path.
- Effective commit j: cm_en[j] && cm_id!=0. Value write: reg_val[id] <= cm_val. When two ports hit the same id, the higher port wins.
- Live clear for commit j: has_dep[id] <= 0 iff tag[id]==cm_tag[j] and no same-cycle dispatch to that id.
- Dispatch: tag[dp_id] <= dp_tag, has_dep <= 1. Dispatch overrides any same-cycle clear of that id.
- Read bypass, per port:
  - val: the highest committing port with matching id, else the array.
  - dep/has_dep: if a same-cycle dispatch targets the id, give dp_tag/1. Else if a commit clears that id, has_dep = 0. Else the array.
  - id 0 always reads 0/0/0.
- Save: snapshot[ck_save_id] <= next-state live tag/has_dep (after this cycle's commits and dispatch); ck_valid bit set. Saving over a valid slot overwrites it.
- Snapshot maintenance: every effective commit also clears has_dep in each valid snapshot whose stored tag for that id matches cm_tag. Values are shared, not snapshotted.
- Restore: live tag/has_dep <= snapshot[ck_rest_id] with same-cycle commit clears applied. Same-cycle dp_en and ck_save are ignored. The restored slot and all other slots stay valid; the ROB releases younger slots via ck_rel. Restoring an invalid slot sets err and leaves the table unchanged.
- Release: clears the ck_valid bit. A save to the same id in the same cycle wins.
- rob_clear (priority over everything except reset): all has_dep and tags = 0; ck_valid = 0. Commits, dispatch, save, restore and release that cycle are ignored, and values are not written.
- Priority: rst_in > !rdy_in hold > rob_clear > ck_rest > normal (commit/dispatch/save/release).
- err is set by a commit whose live has_dep is 0. It clears only on reset.
- Latency: reads are 0 cycles (combinational with bypass); all updates become visible in the array the next cycle.

Decomposition:
- Shared package/include `Config.v` holds ROB_SIZE_BIT (TAG_W default), REG_IDX_W, and the NRD/NCM/NCK defaults.
- One natural sub-module: rf_ckpt_slot, which holds one snapshot with save, commit-clear and restore-out logic. It is instantiated NCK times via generate.
- Bypass/read logic stays in the top.

Test Plan:
- Reset, then read ids 0..31 → all 0/0/0, ck_valid=0, err=0.
- Dispatch x5 tag 3, same cycle read x5 → has_dep=1, dep=3. Next cycle commit x5 tag 3 val 0xDEAD → same-cycle read gives 0xDEAD, has_dep=0; next cycle array holds 0xDEAD, has_dep 0.
- Dispatch x7 tag 2, then dispatch x7 tag 5, then commit x7 tag 2 val 9 → value 9 written, has_dep stays 1, dep 5. Commit and dispatch x7 in the same cycle → dispatch wins.
- Dispatch x8 tag 1, save slot 2, dispatch x8 tag 6, commit x8 tag 1, restore slot 2 → x8 has_dep=0 (snapshot cleared by commit), ck_valid[2]=1.
- Two commit ports to x10 in one cycle, vals 1 and 2 → x10=2. Commit to x0 → ignored. Commit to a register with has_dep=0 → err=1 and stays 1.
- Hold rdy_in low with dispatch active → no change. Then rob_clear with a concurrent commit → all has_dep 0, ck_valid 0, value unchanged. Assert rst_in asynchronously mid-cycle → outputs zero immediately.

Source files
------------

// File: rtl/rf_rename_ckpt_pkg.sv
// Shared configuration for the rename table / register file slice:
// ROB tag width, register index width, port/slot defaults and the
// per-cycle update mode used to order hold, flush, restore and normal work.
package rf_rename_ckpt_pkg;

  localparam int ROB_SIZE_BIT = 4;
  localparam int REG_IDX_W    = 5;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREG     = 1 << REG_IDX_W;
  localparam int DEF_NRD      = 4;
  localparam int DEF_NCM      = 2;
  localparam int DEF_NCK      = 4;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_CLEAR,
    MODE_RESTORE,
    MODE_NORMAL
  } upd_mode_e;

endpackage

// File: rtl/rf_ckpt_slot.sv
// One dependency-table checkpoint: stores tag/has_dep for every register,
// keeps has_dep current as matching producers commit, and presents its
// contents (with this cycle's commit clears folded in) for restore.
module rf_ckpt_slot
  import rf_rename_ckpt_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int TAG_W = ROB_SIZE_BIT,
  parameter int NCM   = DEF_NCM,
  parameter int RW    = $clog2(NREG)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  save_en,
  input  logic [NREG*TAG_W-1:0] save_tag,
  input  logic [NREG-1:0]       save_dep,
  input  logic [NCM-1:0]        cm_eff,
  input  logic [NCM*RW-1:0]     cm_id,
  input  logic [NCM*TAG_W-1:0]  cm_tag,
  output logic [NREG*TAG_W-1:0] snap_tag,
  output logic [NREG-1:0]       snap_dep
);

  logic [NREG*TAG_W-1:0] tag_q;
  logic [NREG-1:0]       dep_q;
  logic [NREG-1:0]       dep_clr;
  logic [TAG_W-1:0]      tag_a [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_unpack
    assign tag_a[r] = tag_q[r*TAG_W +: TAG_W];
  end

  // Drop has_dep for any register whose stored producer is committing now.
  always_comb begin
    dep_clr = dep_q;
    for (int j = 0; j < NCM; j++) begin
      if (cm_eff[j] && (tag_a[cm_id[j*RW +: RW]] == cm_tag[j*TAG_W +: TAG_W])) begin
        dep_clr[cm_id[j*RW +: RW]] = 1'b0;
      end
    end
  end

  // A save replaces the whole image; otherwise only commit clears land.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_q <= '0;
      dep_q <= '0;
    end else if (save_en) begin
      tag_q <= save_tag;
      dep_q <= save_dep;
    end else begin
      dep_q <= dep_clr;
    end
  end

  assign snap_tag = tag_q;
  assign snap_dep = dep_clr;

endmodule

// File: rtl/rf_rename_ckpt.sv
// Architectural register file plus rename table with NRD bypassed read
// ports, NCM commit ports and NCK dependency checkpoints for fast
// mispredict recovery. Values are shared; only tag/has_dep are checkpointed.
module rf_rename_ckpt
  import rf_rename_ckpt_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int TAG_W = ROB_SIZE_BIT,
  parameter int NRD   = DEF_NRD,
  parameter int NCM   = DEF_NCM,
  parameter int NCK   = DEF_NCK,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NCK)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rob_clear,
  input  logic [NCM-1:0]       cm_en,
  input  logic [NCM*RW-1:0]    cm_id,
  input  logic [NCM*TAG_W-1:0] cm_tag,
  input  logic [NCM*XLEN-1:0]  cm_val,
  input  logic                 dp_en,
  input  logic [RW-1:0]        dp_id,
  input  logic [TAG_W-1:0]     dp_tag,
  input  logic                 ck_save,
  input  logic [CW-1:0]        ck_save_id,
  input  logic                 ck_rest,
  input  logic [CW-1:0]        ck_rest_id,
  input  logic                 ck_rel,
  input  logic [CW-1:0]        ck_rel_id,
  input  logic [NRD*RW-1:0]    rd_id,
  output logic [NRD*XLEN-1:0]  rd_val,
  output logic [NRD*TAG_W-1:0] rd_dep,
  output logic [NRD-1:0]       rd_has_dep,
  output logic [NCK-1:0]       ck_valid,
  output logic                 err
);

  logic [XLEN-1:0]       reg_val [NREG];
  logic [TAG_W-1:0]      reg_tag [NREG];
  logic [NREG-1:0]       reg_dep;
  logic [NCK-1:0]        ck_valid_q;
  logic [NCK-1:0]        ck_valid_nxt;
  logic                  err_q;
  logic                  err_set;

  upd_mode_e             mode;
  logic [RW-1:0]         cm_id_a  [NCM];
  logic [TAG_W-1:0]      cm_tag_a [NCM];
  logic [XLEN-1:0]       cm_val_a [NCM];
  logic [RW-1:0]         rd_id_a  [NRD];
  logic [NCM-1:0]        cm_eff;
  logic [NCM-1:0]        cm_clr;
  logic                  dp_eff;

  logic [TAG_W-1:0]      nrm_tag [NREG];
  logic [NREG-1:0]       nrm_dep;
  logic [NREG*TAG_W-1:0] save_tag_flat;

  logic [NREG*TAG_W-1:0] slot_tag [NCK];
  logic [NREG-1:0]       slot_dep [NCK];
  logic [NCK-1:0]        slot_save;
  logic                  rest_ok;
  logic [NREG*TAG_W-1:0] rest_tag;
  logic [NREG-1:0]       rest_dep;

  // Pick which class of update this cycle performs, highest priority first.
  always_comb begin
    mode = MODE_NORMAL;
    if (!rdy_in) begin
      mode = MODE_HOLD;
    end else if (rob_clear) begin
      mode = MODE_CLEAR;
    end else if (ck_rest) begin
      mode = MODE_RESTORE;
    end
  end

  for (genvar j = 0; j < NCM; j++) begin : g_cm
    assign cm_id_a[j]  = cm_id[j*RW +: RW];
    assign cm_tag_a[j] = cm_tag[j*TAG_W +: TAG_W];
    assign cm_val_a[j] = cm_val[j*XLEN +: XLEN];
    assign cm_eff[j]   = ((mode == MODE_NORMAL) || (mode == MODE_RESTORE)) &&
                         cm_en[j] && (cm_id_a[j] != '0);
    assign cm_clr[j]   = cm_eff[j] && (reg_tag[cm_id_a[j]] == cm_tag_a[j]);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_id_a[i] = rd_id[i*RW +: RW];
  end

  assign dp_eff = (mode == MODE_NORMAL) && dp_en && (dp_id != '0);

  // Normal next-state rename table: commit clears first, dispatch overrides.
  always_comb begin
    nrm_dep       = reg_dep;
    save_tag_flat = '0;
    for (int r = 0; r < NREG; r++) begin
      nrm_tag[r] = reg_tag[r];
    end
    for (int j = 0; j < NCM; j++) begin
      if (cm_clr[j]) begin
        nrm_dep[cm_id_a[j]] = 1'b0;
      end
    end
    if (dp_eff) begin
      nrm_tag[dp_id] = dp_tag;
      nrm_dep[dp_id] = 1'b1;
    end
    for (int r = 0; r < NREG; r++) begin
      save_tag_flat[r*TAG_W +: TAG_W] = nrm_tag[r];
    end
  end

  for (genvar k = 0; k < NCK; k++) begin : g_slot
    assign slot_save[k] = (mode == MODE_NORMAL) && ck_save && (ck_save_id == CW'(k));

    rf_ckpt_slot #(
      .NREG  (NREG),
      .TAG_W (TAG_W),
      .NCM   (NCM),
      .RW    (RW)
    ) u_slot (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .save_en  (slot_save[k]),
      .save_tag (save_tag_flat),
      .save_dep (nrm_dep),
      .cm_eff   (cm_eff),
      .cm_id    (cm_id),
      .cm_tag   (cm_tag),
      .snap_tag (slot_tag[k]),
      .snap_dep (slot_dep[k])
    );
  end

  assign rest_ok  = ck_valid_q[ck_rest_id];
  assign rest_tag = slot_tag[ck_rest_id];
  assign rest_dep = slot_dep[ck_rest_id];

  // Sticky error: committing a register with no pending producer, or
  // restoring from an empty checkpoint slot.
  always_comb begin
    err_set = 1'b0;
    for (int j = 0; j < NCM; j++) begin
      if (cm_eff[j] && !reg_dep[cm_id_a[j]]) begin
        err_set = 1'b1;
      end
    end
    if ((mode == MODE_RESTORE) && !rest_ok) begin
      err_set = 1'b1;
    end
  end

  // Slot occupancy: flush empties all, restore leaves all, else release then save.
  always_comb begin
    ck_valid_nxt = ck_valid_q;
    case (mode)
      MODE_CLEAR: ck_valid_nxt = '0;
      MODE_NORMAL: begin
        if (ck_rel) begin
          ck_valid_nxt[ck_rel_id] = 1'b0;
        end
        if (ck_save) begin
          ck_valid_nxt[ck_save_id] = 1'b1;
        end
      end
      default: ck_valid_nxt = ck_valid_q;
    endcase
  end

  // Live rename table update according to the cycle's mode.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        reg_tag[r] <= '0;
      end
      reg_dep <= '0;
    end else begin
      case (mode)
        MODE_CLEAR: begin
          for (int r = 0; r < NREG; r++) begin
            reg_tag[r] <= '0;
          end
          reg_dep <= '0;
        end
        MODE_RESTORE: begin
          if (rest_ok) begin
            for (int r = 0; r < NREG; r++) begin
              reg_tag[r] <= rest_tag[r*TAG_W +: TAG_W];
            end
            reg_dep <= {rest_dep[NREG-1:1], 1'b0};
          end
        end
        MODE_NORMAL: begin
          for (int r = 0; r < NREG; r++) begin
            reg_tag[r] <= nrm_tag[r];
          end
          reg_dep <= nrm_dep;
        end
        default: begin
        end
      endcase
    end
  end

  // Committed values; later (younger) ports overwrite earlier ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        reg_val[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NCM; j++) begin
        if (cm_eff[j]) begin
          reg_val[cm_id_a[j]] <= cm_val_a[j];
        end
      end
    end
  end

  // Slot-valid bitmap and sticky error flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ck_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ck_valid_q <= ck_valid_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ck_valid = ck_valid_q;
  assign err      = err_q;

  // Combinational reads with same-cycle commit and dispatch bypass.
  always_comb begin
    rd_val     = '0;
    rd_dep     = '0;
    rd_has_dep = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_val[i*XLEN +: XLEN]   = reg_val[rd_id_a[i]];
      rd_dep[i*TAG_W +: TAG_W] = reg_tag[rd_id_a[i]];
      rd_has_dep[i]            = reg_dep[rd_id_a[i]];
      for (int j = 0; j < NCM; j++) begin
        if (cm_eff[j] && (cm_id_a[j] == rd_id_a[i])) begin
          rd_val[i*XLEN +: XLEN] = cm_val_a[j];
        end
      end
      if (dp_eff && (dp_id == rd_id_a[i])) begin
        rd_dep[i*TAG_W +: TAG_W] = dp_tag;
        rd_has_dep[i]            = 1'b1;
      end else begin
        for (int j = 0; j < NCM; j++) begin
          if (cm_clr[j] && (cm_id_a[j] == rd_id_a[i])) begin
            rd_has_dep[i] = 1'b0;
          end
        end
      end
      if (rd_id_a[i] == '0) begin
        rd_val[i*XLEN +: XLEN]   = '0;
        rd_dep[i*TAG_W +: TAG_W] = '0;
        rd_has_dep[i]            = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_rename_ckpt.sv
// Directed walk through the rename/checkpoint scenarios followed by a
// randomized run, all compared against a register-level behavioural model.
module tb_rf_rename_ckpt;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         rdy_in;
  logic         rob_clear;
  logic [1:0]   cm_en;
  logic [9:0]   cm_id;
  logic [7:0]   cm_tag;
  logic [63:0]  cm_val;
  logic         dp_en;
  logic [4:0]   dp_id;
  logic [3:0]   dp_tag;
  logic         ck_save;
  logic [1:0]   ck_save_id;
  logic         ck_rest;
  logic [1:0]   ck_rest_id;
  logic         ck_rel;
  logic [1:0]   ck_rel_id;
  logic [19:0]  rd_id;
  logic [127:0] rd_val;
  logic [15:0]  rd_dep;
  logic [3:0]   rd_has_dep;
  logic [3:0]   ck_valid;
  logic         err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_val  [32];
  logic [3:0]  m_tag  [32];
  logic        m_busy [32];
  logic [31:0] p_val  [32];
  logic [3:0]  p_tag  [32];
  logic        p_busy [32];
  logic [3:0]  s_tag  [4][32];
  logic        s_busy [4][32];
  logic [3:0]  s_valid;
  logic        m_err;

  rf_rename_ckpt dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rob_clear  (rob_clear),
    .cm_en      (cm_en),
    .cm_id      (cm_id),
    .cm_tag     (cm_tag),
    .cm_val     (cm_val),
    .dp_en      (dp_en),
    .dp_id      (dp_id),
    .dp_tag     (dp_tag),
    .ck_save    (ck_save),
    .ck_save_id (ck_save_id),
    .ck_rest    (ck_rest),
    .ck_rest_id (ck_rest_id),
    .ck_rel     (ck_rel),
    .ck_rel_id  (ck_rel_id),
    .rd_id      (rd_id),
    .rd_val     (rd_val),
    .rd_dep     (rd_dep),
    .rd_has_dep (rd_has_dep),
    .ck_valid   (ck_valid),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        s_tag[k][r] = '0; s_busy[k][r] = 1'b0;
      end
    end
    s_valid = '0;
    m_err   = 1'b0;
  endtask

  task automatic idle();
    rdy_in = 1'b1; rob_clear = 1'b0;
    cm_en = '0; cm_id = '0; cm_tag = '0; cm_val = '0;
    dp_en = 1'b0; dp_id = '0; dp_tag = '0;
    ck_save = 1'b0; ck_save_id = '0; ck_rest = 1'b0; ck_rest_id = '0;
    ck_rel = 1'b0; ck_rel_id = '0;
  endtask

  task automatic setRd(input int port, input int id);
    rd_id[port*5 +: 5] = 5'(id);
  endtask

  task automatic setCm(input int port, input int id, input int tag, input logic [31:0] val);
    cm_en[port]          = 1'b1;
    cm_id[port*5 +: 5]   = 5'(id);
    cm_tag[port*4 +: 4]  = 4'(tag);
    cm_val[port*32 +: 32] = val;
  endtask

  // What the register view looks like once this cycle's commits and
  // dispatch are taken into account (this is also what reads return).
  task automatic predict();
    int id;
    for (int r = 0; r < 32; r++) begin
      p_val[r] = m_val[r]; p_tag[r] = m_tag[r]; p_busy[r] = m_busy[r];
    end
    if (rdy_in && !rob_clear) begin
      for (int j = 0; j < 2; j++) begin
        id = int'(cm_id[j*5 +: 5]);
        if (cm_en[j] && id != 0) begin
          p_val[id] = cm_val[j*32 +: 32];
          if (m_tag[id] == cm_tag[j*4 +: 4]) p_busy[id] = 1'b0;
        end
      end
      if (!ck_rest && dp_en && dp_id != 0) begin
        p_tag[dp_id]  = dp_tag;
        p_busy[dp_id] = 1'b1;
      end
    end
  endtask

  task automatic modelEdge();
    int id;
    int rs;
    if (!rdy_in) return;
    if (rob_clear) begin
      for (int r = 0; r < 32; r++) begin
        m_tag[r] = '0; m_busy[r] = 1'b0;
      end
      s_valid = '0;
      return;
    end
    for (int j = 0; j < 2; j++) begin
      id = int'(cm_id[j*5 +: 5]);
      if (cm_en[j] && id != 0) begin
        if (!m_busy[id]) m_err = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (s_valid[k] && s_tag[k][id] == cm_tag[j*4 +: 4]) s_busy[k][id] = 1'b0;
        end
      end
    end
    for (int r = 0; r < 32; r++) m_val[r] = p_val[r];
    if (ck_rest) begin
      rs = int'(ck_rest_id);
      if (s_valid[rs]) begin
        for (int r = 0; r < 32; r++) begin
          m_tag[r] = s_tag[rs][r]; m_busy[r] = s_busy[rs][r];
        end
      end else begin
        m_err = 1'b1;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        m_tag[r] = p_tag[r]; m_busy[r] = p_busy[r];
      end
      if (ck_rel) s_valid[ck_rel_id] = 1'b0;
      if (ck_save) begin
        for (int r = 0; r < 32; r++) begin
          s_tag[ck_save_id][r] = p_tag[r]; s_busy[ck_save_id][r] = p_busy[r];
        end
        s_valid[ck_save_id] = 1'b1;
      end
    end
  endtask

  // Called just after a rising edge with inputs set; checks reads at the falling edge.
  task automatic applyStimulus();
    int id;
    predict();
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      id = int'(rd_id[i*5 +: 5]);
      check($sformatf("rd_val[%0d] id%0d", i, id), rd_val[i*32 +: 32], p_val[id]);
      check($sformatf("rd_dep[%0d] id%0d", i, id), {28'b0, rd_dep[i*4 +: 4]}, {28'b0, p_tag[id]});
      check($sformatf("rd_has_dep[%0d] id%0d", i, id), {31'b0, rd_has_dep[i]}, {31'b0, p_busy[id]});
    end
  endtask

  task automatic checkOutput();
    check("ck_valid", {28'b0, ck_valid}, {28'b0, s_valid});
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic clockEdge();
    @(posedge clk_in);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    idle();
    rd_id  = '0;
    rst_in = 1'b1;
    modelReset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Reset contents of every register
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int i = 0; i < 4; i++) setRd(i, c*4 + i);
      applyStimulus();
      check("reset_has_dep", {28'b0, rd_has_dep}, 32'h0);
      clockEdge();
    end
    check("reset_ck_valid", {28'b0, ck_valid}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);

    // Dispatch x5, then commit it
    idle(); setRd(0, 5); dp_en = 1; dp_id = 5; dp_tag = 3;
    applyStimulus();
    check("x5_dp_has_dep", {31'b0, rd_has_dep[0]}, 32'h1);
    check("x5_dp_dep", {28'b0, rd_dep[3:0]}, 32'h3);
    clockEdge();
    idle(); setRd(0, 5); setCm(0, 5, 3, 32'hDEAD);
    applyStimulus();
    check("x5_cm_val", rd_val[31:0], 32'hDEAD);
    check("x5_cm_has_dep", {31'b0, rd_has_dep[0]}, 32'h0);
    clockEdge();
    idle(); setRd(0, 5);
    applyStimulus();
    check("x5_array_val", rd_val[31:0], 32'hDEAD);
    clockEdge();

    // Older producer commits after a newer rename
    idle(); dp_en = 1; dp_id = 7; dp_tag = 2; applyStimulus(); clockEdge();
    idle(); dp_en = 1; dp_id = 7; dp_tag = 5; applyStimulus(); clockEdge();
    idle(); setCm(0, 7, 2, 32'd9); applyStimulus(); clockEdge();
    idle(); setRd(1, 7);
    applyStimulus();
    check("x7_val", rd_val[63:32], 32'd9);
    check("x7_has_dep", {31'b0, rd_has_dep[1]}, 32'h1);
    check("x7_dep", {28'b0, rd_dep[7:4]}, 32'h5);
    clockEdge();
    idle(); setCm(1, 7, 5, 32'd11); dp_en = 1; dp_id = 7; dp_tag = 6; setRd(1, 7);
    applyStimulus(); clockEdge();
    idle(); setRd(1, 7);
    applyStimulus();
    check("x7_dp_wins", {27'b0, rd_dep[7:4], rd_has_dep[1]}, {27'b0, 4'd6, 1'b1});
    clockEdge();

    // Checkpoint recovery
    idle(); dp_en = 1; dp_id = 8; dp_tag = 1; applyStimulus(); clockEdge();
    idle(); ck_save = 1; ck_save_id = 2; applyStimulus(); clockEdge();
    idle(); dp_en = 1; dp_id = 8; dp_tag = 6; applyStimulus(); clockEdge();
    idle(); setCm(0, 8, 1, 32'h88); setRd(2, 8); applyStimulus(); clockEdge();
    idle(); ck_rest = 1; ck_rest_id = 2; applyStimulus(); clockEdge();
    idle(); setRd(2, 8);
    applyStimulus();
    check("x8_restored_has_dep", {31'b0, rd_has_dep[2]}, 32'h0);
    check("ck_valid2_kept", {31'b0, ck_valid[2]}, 32'h1);
    clockEdge();

    // Same-id dual commit, commit to x0, commit without producer
    idle(); dp_en = 1; dp_id = 10; dp_tag = 4; applyStimulus(); clockEdge();
    idle(); setCm(0, 10, 4, 32'd1); setCm(1, 10, 4, 32'd2); setRd(3, 10);
    applyStimulus();
    check("x10_bypass", rd_val[127:96], 32'd2);
    clockEdge();
    idle(); setCm(0, 0, 0, 32'h55); setRd(3, 0);
    applyStimulus(); clockEdge();
    check("x0_no_err", {31'b0, err}, 32'h0);
    idle(); setRd(3, 10);
    applyStimulus();
    check("x10_array", rd_val[127:96], 32'd2);
    clockEdge();
    idle(); setCm(0, 11, 0, 32'h77); applyStimulus(); clockEdge();
    check("err_set", {31'b0, err}, 32'h1);
    idle(); applyStimulus(); clockEdge();
    check("err_sticky", {31'b0, err}, 32'h1);

    // Hold with dispatch pending
    idle(); rdy_in = 0; dp_en = 1; dp_id = 12; dp_tag = 7; setRd(0, 12);
    applyStimulus(); clockEdge();
    idle(); setRd(0, 12);
    applyStimulus();
    check("hold_no_dp", {31'b0, rd_has_dep[0]}, 32'h0);
    clockEdge();

    // Flush with a concurrent commit
    idle(); ck_save = 1; ck_save_id = 1; dp_en = 1; dp_id = 13; dp_tag = 2;
    applyStimulus(); clockEdge();
    idle(); rob_clear = 1; setCm(0, 5, 0, 32'h1234); setRd(0, 5); setRd(1, 13);
    applyStimulus(); clockEdge();
    idle(); setRd(0, 5); setRd(1, 13);
    applyStimulus();
    check("flush_val_kept", rd_val[31:0], 32'hDEAD);
    check("flush_has_dep", {31'b0, rd_has_dep[1]}, 32'h0);
    check("flush_ck_valid", {28'b0, ck_valid}, 32'h0);
    clockEdge();

    // Asynchronous reset mid-cycle
    idle(); ck_save = 1; ck_save_id = 3; applyStimulus(); clockEdge();
    idle(); setRd(0, 5);
    #2;
    rst_in = 1'b1;
    #1;
    modelReset();
    check("async_val", rd_val[31:0], 32'h0);
    check("async_ck_valid", {28'b0, ck_valid}, 32'h0);
    check("async_err", {31'b0, err}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Restore of an empty slot
    idle(); dp_en = 1; dp_id = 4; dp_tag = 9; applyStimulus(); clockEdge();
    idle(); ck_rest = 1; ck_rest_id = 0; setRd(0, 4); applyStimulus(); clockEdge();
    check("bad_restore_err", {31'b0, err}, 32'h1);
    idle(); setRd(0, 4);
    applyStimulus();
    check("bad_restore_keep", {27'b0, rd_dep[3:0], rd_has_dep[0]}, {27'b0, 4'd9, 1'b1});
    clockEdge();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int id;
      idle();
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 2) == 0) begin
          id = int'($urandom_range(0, 15));
          setCm(j, id, ($urandom_range(0, 1) != 0) ? int'(m_tag[id]) : int'($urandom_range(0, 15)), $urandom);
        end
      end
      dp_en      = ($urandom_range(0, 1) != 0);
      dp_id      = 5'($urandom_range(0, 15));
      dp_tag     = 4'($urandom);
      ck_save    = ($urandom_range(0, 5) == 0);
      ck_save_id = 2'($urandom);
      ck_rest    = ($urandom_range(0, 7) == 0);
      ck_rest_id = 2'($urandom);
      ck_rel     = ($urandom_range(0, 5) == 0);
      ck_rel_id  = 2'($urandom);
      setRd(0, int'(dp_id));
      setRd(1, int'(cm_id[4:0]));
      setRd(2, int'(cm_id[9:5]));
      setRd(3, int'($urandom_range(0, 31)));
      applyStimulus();
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
